// File: rtl/ceres_param_pkg.sv
// Shared system parameters and the readback-transmitter state type.
// RAM_DUMP_CHECKSUM_EN adds the CSUM state used for trailing checksum bytes.
package ceres_param;

  localparam int unsigned CPU_CLK        = 50_000_000;
  localparam int unsigned PROG_BAUD_RATE = 115_200;
  localparam int unsigned BLK_SIZE       = 128;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_LATCH,
    ST_SEND,
    ST_NEXT,
    ST_DONE
`ifdef RAM_DUMP_CHECKSUM_EN
    ,
    ST_CSUM
`endif
  } dump_state_e;

  // Byte k of a 32-bit word, little-endian.
  function automatic logic [BYTE_W-1:0] word_byte(input logic [WORD_W-1:0] w,
                                                  input logic [1:0]        k);
    return w[{k, 3'd0} +: BYTE_W];
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 UART transmitter; ready_o also rises in the last stop-bit
// cycle so a following byte can start with no idle gap.
module uart_tx_byte #(
  parameter int unsigned DIV = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       tx_o
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [9:0]    shift_q, shift_d;
  logic [3:0]    bits_q, bits_d;
  logic [CW-1:0] baud_q, baud_d;
  logic          bit_end_c;

  assign bit_end_c = (baud_q == CW'(DIV - 1));
  assign ready_o   = (bits_q == 4'd0) || ((bits_q == 4'd1) && bit_end_c);
  assign tx_o      = shift_q[0];

  always_comb begin
    shift_d = shift_q;
    bits_d  = bits_q;
    baud_d  = baud_q;
    if (bits_q != 4'd0) begin
      if (bit_end_c) begin
        baud_d  = '0;
        bits_d  = bits_q - 4'd1;
        shift_d = {1'b1, shift_q[9:1]};
      end else begin
        baud_d = baud_q + 1'b1;
      end
    end
    if (valid_i && ready_o) begin
      shift_d = {1'b1, data_i, 1'b0};
      bits_d  = 4'd10;
      baud_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= '1;
      bits_q  <= '0;
      baud_q  <= '0;
    end else begin
      shift_q <= shift_d;
      bits_q  <= bits_d;
      baud_q  <= baud_d;
    end
  end

endmodule

// File: rtl/ram_dump_tx.sv
// Reads a word range from the wide program RAM and sends it LSB-byte first on
// a UART line. RAM_DUMP_CHECKSUM_EN appends a little-endian 32-bit word sum.
module ram_dump_tx
  import ceres_param::*;
#(
  parameter int unsigned CLK_FREQ         = CPU_CLK,
  parameter int unsigned BAUD_RATE        = PROG_BAUD_RATE,
  parameter int unsigned CACHE_LINE_WIDTH = BLK_SIZE,
  parameter int unsigned RAM_DEPTH        = 32768
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic [$clog2(RAM_DEPTH)-1:0] start_addr_i,
  input  logic [15:0]                  word_cnt_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [$clog2(RAM_DEPTH)-1:0] ram_addr_o,
  output logic                         ram_rd_en_o,
  input  logic [CACHE_LINE_WIDTH-1:0]  ram_rdata_i,
  output logic                         uart_tx_o
);

  localparam int unsigned AW    = $clog2(RAM_DEPTH);
  localparam int unsigned DIV   = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W = 16;

  dump_state_e                 state_q, state_d;
  logic [AW-1:0]               ptr_q, ptr_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [2:0]                  idx_q, idx_d;
  logic [CACHE_LINE_WIDTH-1:0] line_q, line_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        rd_en_q, rd_en_d;
  logic [AW-1:0]               addr_q, addr_d;
`ifdef RAM_DUMP_CHECKSUM_EN
  logic [WORD_W-1:0]           sum_q, sum_d;
`endif

  logic [WORD_W-1:0] cur_word_c, nxt_word_c, ram_word_c;
  logic [AW-1:0]     ptr_inc_c;
  logic [CNT_W-1:0]  cnt_dec_c;
  logic              tx_valid_c, tx_ready_c;
  logic [BYTE_W-1:0] tx_data_c;

  assign ptr_inc_c  = (ptr_q == AW'(RAM_DEPTH - 1)) ? '0 : ptr_q + 1'b1;
  assign cnt_dec_c  = cnt_q - CNT_W'(1);
  assign cur_word_c = line_q[{ptr_q[1:0], 5'd0} +: WORD_W];
  assign nxt_word_c = line_q[{ptr_inc_c[1:0], 5'd0} +: WORD_W];
  assign ram_word_c = ram_rdata_i[{ptr_q[1:0], 5'd0} +: WORD_W];

  // Next-state; the pointer/count step happens in the stop-bit cycle so that
  // words within one line stream back-to-back.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    line_d     = line_q;
    tx_valid_c = 1'b0;
    tx_data_c  = '0;
`ifdef RAM_DUMP_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          ptr_d   = start_addr_i;
          cnt_d   = word_cnt_i;
          idx_d   = '0;
`ifdef RAM_DUMP_CHECKSUM_EN
          sum_d   = '0;
`endif
          state_d = (word_cnt_i == '0) ? ST_NEXT : ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT:  state_d = ST_LATCH;
      ST_LATCH: begin
        line_d     = ram_rdata_i;
        tx_valid_c = 1'b1;
        tx_data_c  = ram_word_c[BYTE_W-1:0];
        idx_d      = 3'd1;
`ifdef RAM_DUMP_CHECKSUM_EN
        sum_d      = sum_q + ram_word_c;
`endif
        state_d    = ST_SEND;
      end
      ST_SEND: begin
        if (tx_ready_c) begin
          if (idx_q != 3'd4) begin
            tx_valid_c = 1'b1;
            tx_data_c  = word_byte(cur_word_c, idx_q[1:0]);
            idx_d      = idx_q + 3'd1;
          end else begin
            cnt_d = cnt_dec_c;
            ptr_d = ptr_inc_c;
            if ((cnt_dec_c != '0) && (ptr_inc_c[1:0] != 2'd0)) begin
              tx_valid_c = 1'b1;
              tx_data_c  = nxt_word_c[BYTE_W-1:0];
              idx_d      = 3'd1;
`ifdef RAM_DUMP_CHECKSUM_EN
              sum_d      = sum_q + nxt_word_c;
`endif
            end
`ifdef RAM_DUMP_CHECKSUM_EN
            else if (cnt_dec_c == '0) begin
              tx_valid_c = 1'b1;
              tx_data_c  = sum_q[BYTE_W-1:0];
              idx_d      = 3'd1;
              state_d    = ST_CSUM;
            end
`endif
            else begin
              state_d = ST_NEXT;
            end
          end
        end
      end
`ifdef RAM_DUMP_CHECKSUM_EN
      ST_CSUM: begin
        if (tx_ready_c) begin
          if (idx_q != 3'd4) begin
            tx_valid_c = 1'b1;
            tx_data_c  = word_byte(sum_q, idx_q[1:0]);
            idx_d      = idx_q + 3'd1;
          end else begin
            state_d = ST_NEXT;
          end
        end
      end
`endif
      ST_NEXT: state_d = (cnt_q == '0) ? ST_DONE : ST_FETCH;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d  = !((state_d == ST_IDLE) || (state_d == ST_DONE));
    done_d  = (state_d == ST_DONE);
    rd_en_d = (state_d == ST_FETCH);
    addr_d  = rd_en_d ? ptr_d : addr_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      line_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      addr_q  <= '0;
`ifdef RAM_DUMP_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      line_q  <= line_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_en_q <= rd_en_d;
      addr_q  <= addr_d;
`ifdef RAM_DUMP_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign ram_rd_en_o = rd_en_q;
  assign ram_addr_o  = addr_q;

  uart_tx_byte #(
    .DIV (DIV)
  ) u_uart_tx (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (tx_valid_c),
    .data_i  (tx_data_c),
    .ready_o (tx_ready_c),
    .tx_o    (uart_tx_o)
  );

endmodule

// File: tb/tb_ram_dump_tx.sv
// Scoreboard bench for ram_dump_tx: a word-level model predicts serial bytes,
// their start cycles, RAM reads and done pulses; monitors pop and compare.
module tb_ram_dump_tx;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = 6;
  localparam int          DIV   = 4;
  localparam int          FRAME = 10 * DIV;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i;
  logic [AW-1:0] start_addr;
  logic [15:0]   word_cnt;
  logic          busy, done;
  logic [AW-1:0] ram_addr;
  logic          ram_rd_en;
  logic [127:0]  ram_rdata;
  logic          uart_tx;

  ram_dump_tx #(
    .CLK_FREQ         (40),
    .BAUD_RATE        (10),
    .CACHE_LINE_WIDTH (128),
    .RAM_DEPTH        (DEPTH)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start_i),
    .start_addr_i (start_addr),
    .word_cnt_i   (word_cnt),
    .busy_o       (busy),
    .done_o       (done),
    .ram_addr_o   (ram_addr),
    .ram_rd_en_o  (ram_rd_en),
    .ram_rdata_i  (ram_rdata),
    .uart_tx_o    (uart_tx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // RAM with one-cycle registered read of a 4-word line
  logic [31:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_rd_en) begin
      for (int w = 0; w < 4; w++)
        ram_rdata[32*w +: 32] <= mem[(int'(ram_addr) / 4) * 4 + w];
    end
  end

  typedef struct { logic [7:0] b; int t; } ebyte_t;
  typedef struct { int a; int t; } erd_t;
  ebyte_t exp_bytes[$];
  erd_t   exp_rd[$];
  int     exp_done[$];

  // Expected serial/read/done timeline for one dump accepted at cycle n
  task automatic build_model(input int a, input int c, input int n, output int done_t);
    int p;
    int t;
    logic [31:0] w;
    logic [31:0] sum;
    p   = a;
    t   = n + 4;
    sum = '0;
    for (int i = 0; i < c; i++) begin
      if (i > 0 && (p % 4) == 0) t += 4;
      if (i == 0 || (p % 4) == 0) exp_rd.push_back('{a: p, t: t - 3});
      w = mem[p];
      for (int k = 0; k < 4; k++) begin
        exp_bytes.push_back('{b: w[8*k +: 8], t: t});
        t += FRAME;
      end
      sum += w;
      p = (p + 1) % DEPTH;
    end
`ifdef RAM_DUMP_CHECKSUM_EN
    if (c > 0) begin
      for (int k = 0; k < 4; k++) begin
        exp_bytes.push_back('{b: sum[8*k +: 8], t: t});
        t += FRAME;
      end
    end
`endif
    done_t = (c == 0) ? n + 2 : t + 1;
    exp_done.push_back(done_t);
  endtask

  // UART frame monitor: samples each bit in its middle cycle
  bit         in_frame = 1'b0;
  int         fstart;
  int         off_m;
  int         k_m;
  logic [7:0] shreg;
  ebyte_t     eb;
  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 1'b0;
    end else if (!in_frame) begin
      if (uart_tx === 1'b0) begin
        in_frame = 1'b1;
        fstart   = cyc;
      end
    end else begin
      off_m = cyc - fstart;
      if ((off_m % DIV) == DIV / 2) begin
        k_m = off_m / DIV;
        if (k_m >= 1 && k_m <= 8) begin
          shreg[k_m-1] = uart_tx;
        end else if (k_m == 9) begin
          in_frame = 1'b0;
          check("stop_bit", uart_tx, 1);
          if (exp_bytes.size() == 0) begin
            fail_now($sformatf("unexpected_byte got %0h", shreg));
          end else begin
            eb = exp_bytes.pop_front();
            check("tx_byte", shreg, eb.b);
            check("tx_byte_start_cycle", fstart, eb.t);
          end
        end
      end
    end
  end

  erd_t er;
  always @(negedge clk) begin
    if (rst_n && ram_rd_en === 1'b1) begin
      if (exp_rd.size() == 0) begin
        fail_now($sformatf("unexpected_read addr %0d", ram_addr));
      end else begin
        er = exp_rd.pop_front();
        check("read_addr", ram_addr, er.a);
        check("read_cycle", cyc, er.t);
      end
    end
  end

  int ed;
  always @(negedge clk) begin
    if (rst_n && done === 1'b1) begin
      if (exp_done.size() == 0) begin
        fail_now("unexpected_done");
      end else begin
        ed = exp_done.pop_front();
        check("done_cycle", cyc, ed);
        check("busy_at_done", busy, 0);
      end
    end
  end

  task automatic end_checks();
    check("pending_bytes", exp_bytes.size(), 0);
    check("pending_reads", exp_rd.size(), 0);
    check("pending_done", exp_done.size(), 0);
    exp_bytes.delete();
    exp_rd.delete();
    exp_done.delete();
  endtask

  task automatic run_dump(input int a, input int c, input bit poke);
    int n;
    int done_t;
    @(negedge clk);
    start_i    = 1'b1;
    start_addr = AW'(a);
    word_cnt   = 16'(c);
    n          = cyc;
    build_model(a, c, n, done_t);
    @(negedge clk);
    start_i    = 1'b0;
    start_addr = AW'($urandom);
    word_cnt   = 16'($urandom);
    check("busy_after_start", busy, 1);
    if (poke && c > 0) begin
      while (cyc < n + 10) @(negedge clk);
      check("busy_during_dump", busy, 1);
      start_i    = 1'b1;
      start_addr = AW'($urandom_range(0, DEPTH - 1));
      word_cnt   = 16'($urandom_range(1, 3));
      @(negedge clk);
      start_i = 1'b0;
    end
    while (cyc < done_t + 2) @(negedge clk);
    end_checks();
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n      = 1'b0;
    start_i    = 1'b0;
    start_addr = '0;
    word_cnt   = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    mem[0] = 32'h4433_2211;
    mem[8] = 32'h0000_0001;
    mem[9] = 32'hFFFF_FFFF;

    repeat (3) @(negedge clk);
    check("rst_uart_tx", uart_tx, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", ram_rd_en, 0);
    check("rst_addr", ram_addr, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_dump(0, 1, 1'b0);
    run_dump(2, 4, 1'b0);
    run_dump(DEPTH - 1, 2, 1'b0);
    run_dump(0, 0, 1'b0);

    // abort mid start bit
    @(negedge clk);
    start_i    = 1'b1;
    start_addr = AW'(6);
    word_cnt   = 16'd3;
    n          = cyc;
    exp_rd.push_back('{a: 6, t: n + 1});
    @(negedge clk);
    start_i = 1'b0;
    while (cyc < n + 5) @(negedge clk);
    check("tx_low_in_start_bit", uart_tx, 0);
    rst_n = 1'b0;
    #1;
    check("abort_uart_tx", uart_tx, 1);
    check("abort_busy", busy, 0);
    repeat (3) @(negedge clk);
    check("abort_done_low", done, 0);
    rst_n = 1'b1;
    end_checks();
    repeat (2) @(negedge clk);
    run_dump(5, 1, 1'b0);

    run_dump(8, 2, 1'b1);

    for (int r = 0; r < 8; r++) begin
      run_dump($urandom_range(0, DEPTH - 1), $urandom_range(0, 5),
               1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
